// File: rtl/pipe_lane_serializer_if.sv
// pipe_lane_serializer_if
// Valid/ready bundle around the lane serializer: a wide input packet with a
// per-slot mask on the upstream side and one slot per cycle on the
// downstream side.
// master : the serializer's view (drives o_*, samples i_*)
// slave  : the surrounding pipeline's view (drives i_*, samples o_*)

interface pipe_lane_serializer_if #(
    parameter int LANE_W = 32,
    parameter int LANES  = 4
);
    localparam int IDX_W = $clog2(LANES);

    logic [LANES*LANE_W-1:0] i_data;
    logic [LANES-1:0]        i_mask;
    logic                    i_valid;
    logic                    o_ready;
    logic [LANE_W-1:0]       o_data;
    logic [IDX_W-1:0]        o_lane;
    logic                    o_last;
    logic                    o_valid;
    logic                    i_ready;

    modport master (
        input  i_data,
        input  i_mask,
        input  i_valid,
        input  i_ready,
        output o_ready,
        output o_data,
        output o_lane,
        output o_last,
        output o_valid
    );

    modport slave (
        output i_data,
        output i_mask,
        output i_valid,
        output i_ready,
        input  o_ready,
        input  o_data,
        input  o_lane,
        input  o_last,
        input  o_valid
    );
endinterface

// File: rtl/pipe_lane_serializer.sv
// pipe_lane_serializer
// Takes one packet of LANES slots plus a valid mask per handshake and emits
// the masked-in slots one per cycle, lowest lane first. The presented slot
// is always derived from registered state (packet + remaining mask), so it
// is stable under backpressure; the only combinational input-to-output path
// is i_ready -> o_ready, used to accept the next packet while the last slot
// of the current one leaves.
// Optional: define PIPE_LANE_SERIALIZER_STATS_EN to add o_slot_count, a
// saturating count of completed slot transfers cleared only by reset.

module pipe_lane_serializer #(
    parameter int LANE_W = 32,
    parameter int LANES  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    pipe_lane_serializer_if.master bus
`ifdef PIPE_LANE_SERIALIZER_STATS_EN
    ,
    output logic [31:0]            o_slot_count
`endif
);

    localparam int IDX_W = $clog2(LANES);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [LANES*LANE_W-1:0] data_q;
    logic [LANES*LANE_W-1:0] data_d;
    logic [LANES-1:0]        mask_q;
    logic [LANES-1:0]        mask_d;

    logic [IDX_W-1:0]        cur_lane;
    logic [LANE_W-1:0]       cur_slot;
    logic                    is_last;
    logic                    sending;
    logic                    ready;
    logic                    accept;
    logic                    transfer;

    // Priority encoder: index of the lowest set bit (0 when the mask is empty).
    function automatic logic [IDX_W-1:0] lowest_lane(input logic [LANES-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (m[k]) begin
                idx = IDX_W'(k);
            end
        end
        return idx;
    endfunction

    // Select the slot under the lowest remaining lane and decide if it is the last one.
    always_comb begin
        cur_lane = lowest_lane(mask_q);
        cur_slot = '0;
        for (int k = 0; k < LANES; k++) begin
            if (IDX_W'(k) == cur_lane) begin
                cur_slot = data_q[k*LANE_W +: LANE_W];
            end
        end
        sending = (state_q == SEND);
        is_last = sending && ((mask_q >> cur_lane) == LANES'(1));
    end

    // Upstream ready: always in IDLE, and in SEND only while the last slot leaves.
    always_comb begin
        ready = 1'b0;
        if (reset) begin
            unique case (state_q)
                IDLE:    ready = 1'b1;
                SEND:    ready = bus.i_ready && is_last;
                default: ready = 1'b0;
            endcase
        end
        accept   = bus.i_valid && ready;
        transfer = sending && bus.i_ready;
    end

    // Next-state logic: flush wins, then load/advance/finish the packet.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        if (flush) begin
            state_d = IDLE;
            mask_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && (bus.i_mask != '0)) begin
                        state_d = SEND;
                        data_d  = bus.i_data;
                        mask_d  = bus.i_mask;
                    end
                end
                SEND: begin
                    if (transfer) begin
                        if (is_last) begin
                            if (accept && (bus.i_mask != '0)) begin
                                state_d = SEND;
                                data_d  = bus.i_data;
                                mask_d  = bus.i_mask;
                            end else begin
                                state_d = IDLE;
                                mask_d  = '0;
                            end
                        end else begin
                            mask_d = mask_q & ~(LANES'(1) << cur_lane);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    mask_d  = '0;
                end
            endcase
        end
    end

    // State, held packet and remaining mask; cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    // Drive the downstream side; data/lane read as zero when nothing is presented.
    always_comb begin
        bus.o_ready = ready;
        bus.o_valid = sending;
        bus.o_last  = is_last;
        bus.o_data  = sending ? cur_slot : '0;
        bus.o_lane  = sending ? cur_lane : '0;
    end

`ifdef PIPE_LANE_SERIALIZER_STATS_EN
    logic [31:0] slot_count_q;

    // Saturating count of completed slot transfers; flush does not touch it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_count_q <= '0;
        end else if (transfer && (slot_count_q != 32'hFFFF_FFFF)) begin
            slot_count_q <= slot_count_q + 32'd1;
        end
    end

    assign o_slot_count = slot_count_q;
`endif

endmodule

// File: tb/tb_pipe_lane_serializer.sv
// tb_pipe_lane_serializer
// Self-checking bench: each accepted packet pushes its expected slots into a
// scoreboard queue, and a negedge monitor pops and compares every slot that
// transfers downstream. Cycle-level checks cover reset, latency, backpressure,
// back-to-back packets, empty masks and flush.

module tb_pipe_lane_serializer;

    localparam int LANE_W = 32;
    localparam int LANES  = 4;
    localparam int IDX_W  = 2;

    typedef struct packed {
        logic [LANE_W-1:0] data;
        logic [IDX_W-1:0]  lane;
        logic              last;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    pipe_lane_serializer_if #(.LANE_W(LANE_W), .LANES(LANES)) bus ();

`ifdef PIPE_LANE_SERIALIZER_STATS_EN
    logic [31:0] slot_count;
`endif

    pipe_lane_serializer #(.LANE_W(LANE_W), .LANES(LANES)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .bus          (bus.master)
`ifdef PIPE_LANE_SERIALIZER_STATS_EN
        ,
        .o_slot_count (slot_count)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [LANES*LANE_W-1:0] PKT1 = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    localparam logic [LANES*LANE_W-1:0] PKTA = {32'h0A0A_0003, 32'h0A0A_0002, 32'h0A0A_0001, 32'h0A0A_1111};
    localparam logic [LANES*LANE_W-1:0] PKTB = {32'h0B0B_3333, 32'h0B0B_0002, 32'h0B0B_0001, 32'h0B0B_0000};
    localparam logic [LANES*LANE_W-1:0] PKTC = {32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic rst_n, input logic fl, input logic valid,
                                 input logic [LANES*LANE_W-1:0] data, input logic [LANES-1:0] mask,
                                 input logic rdy);
        @(posedge clk);
        #1;
        reset       = rst_n;
        flush       = fl;
        bus.i_valid = valid;
        bus.i_data  = data;
        bus.i_mask  = mask;
        bus.i_ready = rdy;
    endtask

    // Queue the expected slots of a packet (at most max_slots of them).
    task automatic pushPacket(input logic [LANES*LANE_W-1:0] data, input logic [LANES-1:0] mask,
                              input int max_slots);
        int   hi;
        int   pushed;
        exp_t e;
        hi     = -1;
        pushed = 0;
        for (int k = 0; k < LANES; k++) begin
            if (mask[k]) hi = k;
        end
        for (int k = 0; k < LANES; k++) begin
            if (mask[k] && (pushed < max_slots)) begin
                e.data = data[k*LANE_W +: LANE_W];
                e.lane = IDX_W'(k);
                e.last = (k == hi);
                sb.push_back(e);
                pushed++;
            end
        end
    endtask

    task automatic expectSlot(input string tag, input logic valid, input logic [IDX_W-1:0] lane,
                              input logic last);
        @(negedge clk);
        checkOutput({tag, "_valid"}, bus.o_valid, valid);
        if (valid) begin
            checkOutput({tag, "_lane"}, bus.o_lane, lane);
            checkOutput({tag, "_last"}, bus.o_last, last);
        end
    endtask

    // Scoreboard monitor: every downstream transfer must match the next queued slot.
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.o_valid && bus.i_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_slot", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("slot_data", bus.o_data, e.data);
                checkOutput("slot_lane", bus.o_lane, e.lane);
                checkOutput("slot_last", bus.o_last, e.last);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.i_data  = PKT1;
        bus.i_mask  = 4'b1111;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;

        // Reset held for three cycles with a valid packet offered
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("rst_o_valid", bus.o_valid, 1'b0);
            checkOutput("rst_o_ready", bus.o_ready, 1'b0);
        end
        checkOutput("rst_o_data", bus.o_data, '0);
        checkOutput("rst_o_lane", bus.o_lane, '0);
        checkOutput("rst_o_last", bus.o_last, 1'b0);
        applyStimulus(1, 0, 0, '0, '0, 1);
        @(negedge clk);
        checkOutput("post_rst_ready", bus.o_ready, 1'b1);
        checkOutput("post_rst_valid", bus.o_valid, 1'b0);

        // Mask 1011, continuous ready: lanes 0,1,3 back to back
        applyStimulus(1, 0, 1, PKT1, 4'b1011, 1);
        pushPacket(PKT1, 4'b1011, LANES);
        @(negedge clk);
        checkOutput("s1_accept_ready", bus.o_ready, 1'b1);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s1_c1", 1, 0, 0);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s1_c2", 1, 1, 0);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s1_c3", 1, 3, 1);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s1_c4", 0, 0, 0);

        // Same packet with backpressure while lane 1 is presented
        applyStimulus(1, 0, 1, PKT1, 4'b1011, 1);
        pushPacket(PKT1, 4'b1011, LANES);
        @(negedge clk);
        checkOutput("s2_accept_ready", bus.o_ready, 1'b1);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s2_c1", 1, 0, 0);
        applyStimulus(1, 0, 0, '0, '0, 0);
        expectSlot("s2_stall1", 1, 1, 0);
        checkOutput("s2_stall1_data", bus.o_data, 32'hBBBB_0001);
        checkOutput("s2_stall1_ready", bus.o_ready, 1'b0);
        applyStimulus(1, 0, 0, '0, '0, 0);
        expectSlot("s2_stall2", 1, 1, 0);
        checkOutput("s2_stall2_data", bus.o_data, 32'hBBBB_0001);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s2_resume", 1, 1, 0);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s2_c3", 1, 3, 1);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s2_done", 0, 0, 0);

        // Back-to-back single-slot packets, no bubble
        applyStimulus(1, 0, 1, PKTA, 4'b0001, 1);
        pushPacket(PKTA, 4'b0001, LANES);
        @(negedge clk);
        checkOutput("s3_accept_a", bus.o_ready, 1'b1);
        applyStimulus(1, 0, 1, PKTB, 4'b1000, 1);
        pushPacket(PKTB, 4'b1000, LANES);
        expectSlot("s3_a", 1, 0, 1);
        checkOutput("s3_last_ready", bus.o_ready, 1'b1);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s3_b", 1, 3, 1);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s3_done", 0, 0, 0);

        // Empty mask is consumed silently
        applyStimulus(1, 0, 1, PKTC, 4'b0000, 1);
        @(negedge clk);
        checkOutput("s4_empty_ready", bus.o_ready, 1'b1);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s4_empty_out", 0, 0, 0);
        checkOutput("s4_empty_ready2", bus.o_ready, 1'b1);

        // Flush while lane 1 of a full packet is presented
        applyStimulus(1, 0, 1, PKTC, 4'b1111, 1);
        pushPacket(PKTC, 4'b1111, 2);
        @(negedge clk);
        checkOutput("s4_accept_ready", bus.o_ready, 1'b1);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s4_l0", 1, 0, 0);
        applyStimulus(1, 1, 0, '0, '0, 1);
        expectSlot("s4_l1", 1, 1, 0);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s4_flushed", 0, 0, 0);
        checkOutput("s4_flush_ready", bus.o_ready, 1'b1);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s4_quiet1", 0, 0, 0);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s4_quiet2", 0, 0, 0);

        // Packet handshaken during a flush cycle is discarded
        applyStimulus(1, 1, 1, PKTA, 4'b1111, 1);
        @(negedge clk);
        checkOutput("s5_flush_accept_ready", bus.o_ready, 1'b1);
        applyStimulus(1, 0, 0, '0, '0, 1);
        expectSlot("s5_discarded", 0, 0, 0);

        @(negedge clk);
        #1;
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
`ifdef PIPE_LANE_SERIALIZER_STATS_EN
        checkOutput("slot_count", slot_count, 32'd10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
